// File: rtl/axi_ram_wr_if.sv
// AXI4 write-channel front end for RAM-backed slaves.
// Accepts one AW burst at a time, emits one RAM write command per W beat with
// an incrementing per-beat address, then returns a single OKAY B response.
module axi_ram_wr_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 8,
  parameter bit AWUSER_ENABLE = 1'b0,
  parameter int AWUSER_WIDTH  = 1,
  parameter bit WUSER_ENABLE  = 1'b0,
  parameter int WUSER_WIDTH   = 1,
  parameter int BUSER_WIDTH   = 1
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awqos,
  input  logic [3:0]              s_axi_awregion,
  input  logic [AWUSER_WIDTH-1:0] s_axi_awuser,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,

  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [STRB_WIDTH-1:0]   s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic [WUSER_WIDTH-1:0]  s_axi_wuser,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,

  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic [BUSER_WIDTH-1:0]  s_axi_buser,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,

  output logic [ID_WIDTH-1:0]     ram_wr_cmd_id,
  output logic [ADDR_WIDTH-1:0]   ram_wr_cmd_addr,
  output logic                    ram_wr_cmd_lock,
  output logic [3:0]              ram_wr_cmd_cache,
  output logic [2:0]              ram_wr_cmd_prot,
  output logic [3:0]              ram_wr_cmd_qos,
  output logic [3:0]              ram_wr_cmd_region,
  output logic [AWUSER_WIDTH-1:0] ram_wr_cmd_auser,
  output logic [DATA_WIDTH-1:0]   ram_wr_cmd_data,
  output logic [STRB_WIDTH-1:0]   ram_wr_cmd_strb,
  output logic [WUSER_WIDTH-1:0]  ram_wr_cmd_wuser,
  output logic                    ram_wr_cmd_en,
  output logic                    ram_wr_cmd_last,
  input  logic                    ram_wr_cmd_ready
);

  // Widest transfer size the data bus can carry; larger awsize is clamped.
  localparam logic [2:0] SIZE_MAX = 3'($clog2(STRB_WIDTH));

  typedef enum logic [1:0] {StIdle, StBurst, StResp} state_t;

  state_t                  r_state;
  logic                    r_awready;
  logic                    r_bvalid;
  logic [ID_WIDTH-1:0]     r_bid;
  logic [ID_WIDTH-1:0]     r_id;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_lock;
  logic [3:0]              r_cache;
  logic [2:0]              r_prot;
  logic [3:0]              r_qos;
  logic [3:0]              r_region;
  logic [AWUSER_WIDTH-1:0] r_auser;
  logic [7:0]              r_count;
  logic [2:0]              r_size;
  logic [1:0]              r_burst;

  logic                    w_in_burst;
  logic                    w_beat;
  logic [2:0]              w_size_clamp;
  logic [ADDR_WIDTH-1:0]   w_addr_step;
  logic                    w_unused;

  // Beat handshake and per-beat address step.
  always_comb begin
    w_in_burst   = (r_state == StBurst);
    w_beat       = w_in_burst && s_axi_wvalid && ram_wr_cmd_ready;
    w_size_clamp = (s_axi_awsize > SIZE_MAX) ? SIZE_MAX : s_axi_awsize;
    w_addr_step  = ADDR_WIDTH'(1) << r_size;
  end

  // wlast is deliberately ignored: the latched awlen decides the last beat.
  assign w_unused = ^{s_axi_wlast};

  // Burst FSM: latch AW, walk the beats, hold the B response until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_id      <= '0;
      r_addr    <= '0;
      r_lock    <= 1'b0;
      r_cache   <= '0;
      r_prot    <= '0;
      r_qos     <= '0;
      r_region  <= '0;
      r_auser   <= '0;
      r_count   <= '0;
      r_size    <= '0;
      r_burst   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (r_awready && s_axi_awvalid) begin
            r_id      <= s_axi_awid;
            r_addr    <= s_axi_awaddr;
            r_lock    <= s_axi_awlock;
            r_cache   <= s_axi_awcache;
            r_prot    <= s_axi_awprot;
            r_qos     <= s_axi_awqos;
            r_region  <= s_axi_awregion;
            r_auser   <= s_axi_awuser;
            r_count   <= s_axi_awlen;
            r_size    <= w_size_clamp;
            r_burst   <= s_axi_awburst;
            r_awready <= 1'b0;
            r_state   <= StBurst;
          end else begin
            r_awready <= 1'b1;
          end
        end
        StBurst: begin
          if (w_beat) begin
            // FIXED keeps the address; WRAP is handled like INCR.
            if (r_burst != 2'b00) begin
              r_addr <= r_addr + w_addr_step;
            end
            r_count <= r_count - 8'd1;
            if (r_count == 8'd0) begin
              r_bvalid <= 1'b1;
              r_bid    <= r_id;
              r_state  <= StResp;
            end
          end
        end
        StResp: begin
          if (s_axi_bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = w_in_burst && ram_wr_cmd_ready;

  assign s_axi_bid     = r_bid;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_buser   = '0;
  assign s_axi_bvalid  = r_bvalid;

  assign ram_wr_cmd_id     = r_id;
  assign ram_wr_cmd_addr   = r_addr;
  assign ram_wr_cmd_lock   = r_lock;
  assign ram_wr_cmd_cache  = r_cache;
  assign ram_wr_cmd_prot   = r_prot;
  assign ram_wr_cmd_qos    = r_qos;
  assign ram_wr_cmd_region = r_region;
  assign ram_wr_cmd_auser  = AWUSER_ENABLE ? r_auser : '0;
  assign ram_wr_cmd_data   = s_axi_wdata;
  assign ram_wr_cmd_strb   = s_axi_wstrb;
  assign ram_wr_cmd_wuser  = WUSER_ENABLE ? s_axi_wuser : '0;
  assign ram_wr_cmd_en     = w_in_burst && s_axi_wvalid;
  assign ram_wr_cmd_last   = (r_count == 8'd0);

endmodule

// File: tb/tb_axi_ram_wr_if.sv
// Directed bench for axi_ram_wr_if with a command/response scoreboard.
module tb_axi_ram_wr_if;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  awid;
  logic [15:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic [3:0]  awqos;
  logic [3:0]  awregion;
  logic [0:0]  awuser;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic [0:0]  wuser;
  logic        wvalid;
  logic        wready;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic [0:0]  buser;
  logic        bvalid;
  logic        bready;
  logic [7:0]  cmd_id;
  logic [15:0] cmd_addr;
  logic        cmd_lock;
  logic [3:0]  cmd_cache;
  logic [2:0]  cmd_prot;
  logic [3:0]  cmd_qos;
  logic [3:0]  cmd_region;
  logic [0:0]  cmd_auser;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_strb;
  logic [0:0]  cmd_wuser;
  logic        cmd_en;
  logic        cmd_last;
  logic        ram_ready;

  axi_ram_wr_if dut (
    .clk               (clk),
    .rst               (rst),
    .s_axi_awid        (awid),
    .s_axi_awaddr      (awaddr),
    .s_axi_awlen       (awlen),
    .s_axi_awsize      (awsize),
    .s_axi_awburst     (awburst),
    .s_axi_awlock      (awlock),
    .s_axi_awcache     (awcache),
    .s_axi_awprot      (awprot),
    .s_axi_awqos       (awqos),
    .s_axi_awregion    (awregion),
    .s_axi_awuser      (awuser),
    .s_axi_awvalid     (awvalid),
    .s_axi_awready     (awready),
    .s_axi_wdata       (wdata),
    .s_axi_wstrb       (wstrb),
    .s_axi_wlast       (wlast),
    .s_axi_wuser       (wuser),
    .s_axi_wvalid      (wvalid),
    .s_axi_wready      (wready),
    .s_axi_bid         (bid),
    .s_axi_bresp       (bresp),
    .s_axi_buser       (buser),
    .s_axi_bvalid      (bvalid),
    .s_axi_bready      (bready),
    .ram_wr_cmd_id     (cmd_id),
    .ram_wr_cmd_addr   (cmd_addr),
    .ram_wr_cmd_lock   (cmd_lock),
    .ram_wr_cmd_cache  (cmd_cache),
    .ram_wr_cmd_prot   (cmd_prot),
    .ram_wr_cmd_qos    (cmd_qos),
    .ram_wr_cmd_region (cmd_region),
    .ram_wr_cmd_auser  (cmd_auser),
    .ram_wr_cmd_data   (cmd_data),
    .ram_wr_cmd_strb   (cmd_strb),
    .ram_wr_cmd_wuser  (cmd_wuser),
    .ram_wr_cmd_en     (cmd_en),
    .ram_wr_cmd_last   (cmd_last),
    .ram_wr_cmd_ready  (ram_ready)
  );

  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } cmd_t;

  cmd_t       exp_q[$];
  logic [7:0] exp_b[$];
  cmd_t       mon_e;
  logic [7:0] mon_b;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop an expected command per RAM beat, an expected id per B.
  always @(negedge clk) begin
    if (cmd_en && ram_ready) begin
      if (exp_q.size() == 0) begin
        check("cmd_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("cmd_id", 64'(cmd_id), 64'(mon_e.id));
        check("cmd_addr", 64'(cmd_addr), 64'(mon_e.addr));
        check("cmd_data", 64'(cmd_data), 64'(mon_e.data));
        check("cmd_strb", 64'(cmd_strb), 64'(mon_e.strb));
        check("cmd_last", 64'(cmd_last), 64'(mon_e.last));
        check("cmd_prot", 64'(cmd_prot), 64'h2);
      end
    end
    if (bvalid && bready) begin
      if (exp_b.size() == 0) begin
        check("b_unexpected", 64'd1, 64'd0);
      end else begin
        mon_b = exp_b.pop_front();
        check("b_id", 64'(bid), 64'(mon_b));
        check("b_resp", 64'(bresp), 64'd0);
        check("b_user", 64'(buser), 64'd0);
      end
    end
  end

  // Push the expected beats and response, then perform the AW handshake.
  task automatic aw_send(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input logic [31:0] base);
    logic [15:0] a;
    logic [31:0] d;
    int          sz;
    bit          got;
    a   = addr;
    got = 1'b0;
    sz  = (size > 3'd2) ? 2 : int'(size);
    for (int i = 0; i <= int'(len); i++) begin
      d = base + 32'(i);
      exp_q.push_back('{id: id, addr: a, data: d, strb: d[3:0], last: (i == int'(len))});
      if (burst != 2'b00) a = a + (16'd1 << sz);
    end
    exp_b.push_back(id);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    awvalid = 1'b1;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      got = awready;
      @(posedge clk); #1;
    end
    awvalid = 1'b0;
    check("aw_handshake", 64'(got), 64'd1);
  endtask

  // Drive nbeats W beats; optional RAM backpressure and wvalid gaps.
  task automatic w_send(input int len, input logic [31:0] base, input int nbeats,
                        input bit bp, input bit gap, output int cycles);
    int          beat;
    int          c;
    bit          hs;
    logic [31:0] d;
    beat = 0;
    c    = 0;
    while (beat < nbeats && c < 200) begin
      d         = base + 32'(beat);
      wvalid    = gap ? (c % 3 != 2) : 1'b1;
      wdata     = d;
      wstrb     = d[3:0];
      wlast     = (beat == len);
      ram_ready = bp ? (c % 2 == 0) : 1'b1;
      @(negedge clk);
      check("wready_mirror", 64'(wready), 64'(ram_ready));
      check("cmd_en_mirror", 64'(cmd_en), 64'(wvalid));
      check("awready_busy", 64'(awready), 64'd0);
      hs = wvalid && wready;
      @(posedge clk); #1;
      if (hs) beat++;
      c++;
    end
    wvalid    = 1'b0;
    ram_ready = 1'b1;
    check("w_beats_done", 64'(beat), 64'(nbeats));
    cycles = c;
  endtask

  // Optionally stall bready, then take the B response and check awready returns.
  task automatic b_recv(input logic [7:0] id, input int hold);
    bit got;
    got = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("b_hold_valid", 64'(bvalid), 64'd1);
      check("b_hold_id", 64'(bid), 64'(id));
      check("b_hold_awready", 64'(awready), 64'd0);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = bvalid;
      @(posedge clk); #1;
    end
    bready = 1'b0;
    check("b_handshake", 64'(got), 64'd1);
    @(negedge clk);
    check("awready_after_b", 64'(awready), 64'd1);
    check("bvalid_after_b", 64'(bvalid), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic burst(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] bt, input logic [31:0] base,
                       input bit bp, input bit gap, input int hold, output int cycles);
    aw_send(id, addr, len, size, bt, base);
    w_send(int'(len), base, int'(len) + 1, bp, gap, cycles);
    b_recv(id, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    awlock = 1'b0; awcache = 4'h3; awprot = 3'h2; awqos = '0; awregion = '0;
    awuser = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wuser = '0; wvalid = 1'b0;
    bready = 1'b0; ram_ready = 1'b1;

    #1 rst = 1'b1;
    #2;
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_bid", 64'(bid), 64'd0);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_cmd_en", 64'(cmd_en), 64'd0);
    check("rst_cmd_addr", 64'(cmd_addr), 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("rst_awready_held", 64'(awready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("awready_after_rst", 64'(awready), 64'd1);
    @(posedge clk); #1;

    // Single beat.
    burst(8'h11, 16'h0010, 8'd0, 3'd2, 2'b01, 32'hDEADBEEF, 1'b0, 1'b0, 0, cyc);
    // INCR x4, one beat per cycle.
    burst(8'h22, 16'h0100, 8'd3, 3'd2, 2'b01, 32'h0000_0100, 1'b0, 1'b0, 0, cyc);
    check("incr_sustained_cycles", 64'(cyc), 64'd4);
    // FIXED x3 stays at one address.
    burst(8'h23, 16'h0080, 8'd2, 3'd2, 2'b00, 32'h0000_0200, 1'b0, 1'b0, 0, cyc);
    // Narrow byte burst.
    burst(8'h24, 16'h0020, 8'd1, 3'd0, 2'b01, 32'h0000_0300, 1'b0, 1'b0, 0, cyc);
    // awsize=3 clamps to 4-byte steps.
    burst(8'h25, 16'h0040, 8'd1, 3'd3, 2'b01, 32'h0000_0400, 1'b0, 1'b0, 0, cyc);
    // RAM backpressure and wvalid gaps.
    burst(8'h26, 16'h0300, 8'd5, 3'd2, 2'b01, 32'h0000_0500, 1'b1, 1'b1, 0, cyc);
    // Address wrap with bready stalled 5 cycles.
    burst(8'h27, 16'hFFFC, 8'd1, 3'd2, 2'b01, 32'h0000_0600, 1'b0, 1'b0, 5, cyc);

    // Reset during beat 2 of 4.
    aw_send(8'h33, 16'h0200, 8'd3, 3'd2, 2'b01, 32'h0000_5000);
    w_send(3, 32'h0000_5000, 1, 1'b0, 1'b0, cyc);
    wvalid = 1'b1;
    wdata  = 32'h0000_5001;
    wstrb  = 4'h1;
    #1;
    check("cmd_en_pre_rst", 64'(cmd_en), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_cmd_en", 64'(cmd_en), 64'd0);
    check("rst_mid_bvalid", 64'(bvalid), 64'd0);
    check("rst_mid_wready", 64'(wready), 64'd0);
    check("rst_mid_awready", 64'(awready), 64'd0);
    exp_q.delete();
    exp_b.delete();
    @(negedge clk);
    rst    = 1'b0;
    wvalid = 1'b0;
    @(negedge clk);
    check("awready_after_mid_rst", 64'(awready), 64'd1);
    @(posedge clk); #1;
    burst(8'h44, 16'h0400, 8'd2, 3'd2, 2'b01, 32'h0000_6000, 1'b0, 1'b0, 0, cyc);

    check("sb_cmd_empty", 64'(exp_q.size()), 64'd0);
    check("sb_b_empty", 64'(exp_b.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
